// File: rtl/xxd_dl_pkg.sv
// Shared constants and helpers for the xxd_delay_line circular-buffer delay line.
// Delay classification, clamping and read-pointer arithmetic live here.
package xxd_dl_pkg;

    localparam int unsigned XXD_WIDTH_DEF = 32'd8;
    localparam int unsigned XXD_DEPTH_DEF = 32'd256;

    typedef enum logic [1:0] {
        DLY_OK   = 2'd0,
        DLY_LOW  = 2'd1,
        DLY_HIGH = 2'd2
    } dly_range_e;

    function automatic dly_range_e classify_delay(input int unsigned req,
                                                  input int unsigned depth,
                                                  input logic        zero_ok);
        dly_range_e r;
        if (req == 32'd0) begin
            r = zero_ok ? DLY_OK : DLY_LOW;
        end else if (req > depth) begin
            r = DLY_HIGH;
        end else begin
            r = DLY_OK;
        end
        return r;
    endfunction

    // A zero result is only possible when the zero-delay pass-through is allowed.
    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned depth,
                                                input logic        zero_ok);
        int unsigned d;
        case (classify_delay(req, depth, zero_ok))
            DLY_LOW:  d = 32'd1;
            DLY_HIGH: d = depth;
            default:  d = req;
        endcase
        return d;
    endfunction

    // Slot holding sample n-D+1 when sample n is being written at wr.
    function automatic int unsigned rd_index(input int unsigned wr,
                                             input int unsigned d,
                                             input int unsigned depth);
        return (wr + depth + 32'd1 - d) % depth;
    endfunction

endpackage

// File: rtl/xxd_dl_ram.sv
// DEPTH x WIDTH simple dual-port RAM: one write port, one registered read port.
// Contents are never cleared; the read register holds when re_i is low.
module xxd_dl_ram
    import xxd_dl_pkg::*;
#(
    parameter  int unsigned WIDTH = XXD_WIDTH_DEF,
    parameter  int unsigned DEPTH = XXD_DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and synchronous read port share the single clock.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xxd_delay_line.sv
// xxd_delay_line: WIDTH-bit, DEPTH-entry circular-buffer delay line, runtime delay 1..DEPTH.
// Optional XXD_DELAY_LINE_BYPASS_EN makes delay=0 a legal combinational pass-through.
module xxd_delay_line
    import xxd_dl_pkg::*;
#(
    parameter  int unsigned WIDTH = XXD_WIDTH_DEF,
    parameter  int unsigned DEPTH = XXD_DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [AW:0]      delay_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    output logic [AW:0]      fill_o,
    output logic             delay_err_o
);

`ifdef XXD_DELAY_LINE_BYPASS_EN
    localparam logic ZERO_OK = 1'b1;
`else
    localparam logic ZERO_OK = 1'b0;
`endif

    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_V   = (AW+1)'(1'b1);
    localparam logic [AW:0]   ZERO_V  = {(AW+1){1'b0}};
    localparam logic [AW-1:0] PTR_INC = AW'(1'b1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic [AW:0]      delay_q, delay_d;
    logic             delay_err_q, delay_err_d;
    logic             valid_q, valid_d;
    logic             fwd_sel_q, fwd_sel_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [AW:0]      fill_eff_s;
    logic [AW-1:0]    rd_addr_s;
    logic             we_s;
    logic             bypass_s;
    logic [WIDTH-1:0] ram_rdata_s;
    logic [WIDTH-1:0] dout_reg_s;

    // Next-state: a change of clamped delay flushes fill before this cycle's sample counts.
    always_comb begin
        delay_d     = (AW+1)'(clamp_delay(32'(delay_i), DEPTH, ZERO_OK));
        delay_err_d = (classify_delay(32'(delay_i), DEPTH, ZERO_OK) != DLY_OK);
        rd_addr_s   = AW'(rd_index(32'(wr_ptr_q), 32'(delay_d), DEPTH));
        we_s        = en_i & ~rst_i;
        wr_ptr_d    = wr_ptr_q;
        valid_d     = 1'b0;
        fwd_sel_d   = fwd_sel_q;
        fwd_data_d  = fwd_data_q;
        if (delay_d != delay_q) begin
            fill_eff_s = ZERO_V;
        end else begin
            fill_eff_s = fill_q;
        end
        fill_d = fill_eff_s;
        if (en_i) begin
            wr_ptr_d   = wr_ptr_q + PTR_INC;
            fill_d     = (fill_eff_s == DEPTH_V) ? fill_eff_s : fill_eff_s + ONE_V;
            valid_d    = (delay_d != ZERO_V) && ((fill_eff_s + ONE_V) >= delay_d);
            fwd_sel_d  = (delay_d == ONE_V);
            fwd_data_d = din_i;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // State registers; reset forces the forward path so dout reads back zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= {AW{1'b0}};
            fill_q      <= ZERO_V;
            delay_q     <= ONE_V;
            delay_err_q <= 1'b0;
            valid_q     <= 1'b0;
            fwd_sel_q   <= 1'b1;
            fwd_data_q  <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            delay_q     <= delay_d;
            delay_err_q <= delay_err_d;
            valid_q     <= valid_d;
            fwd_sel_q   <= fwd_sel_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    xxd_dl_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_i),
        .re_i    (we_s),
        .raddr_i (rd_addr_s),
        .rdata_o (ram_rdata_s)
    );

    assign dout_reg_s = fwd_sel_q ? fwd_data_q : ram_rdata_s;

`ifdef XXD_DELAY_LINE_BYPASS_EN
    assign bypass_s = (delay_i == ZERO_V);
`else
    assign bypass_s = 1'b0;
`endif

    // Output select: pass-through only when zero delay is enabled and requested.
    always_comb begin
        if (bypass_s) begin
            dout_o       = din_i;
            dout_valid_o = en_i;
        end else begin
            dout_o       = dout_reg_s;
            dout_valid_o = valid_q;
        end
    end

    assign fill_o      = fill_q;
    assign delay_err_o = delay_err_q;

endmodule

// File: tb/tb_xxd_delay_line.sv
// Self-checking bench for xxd_delay_line (WIDTH=8, DEPTH=16): vector table, directed
// corner sequences and randomized traffic against a sample-history reference model.
module tb_xxd_delay_line;

    localparam int DEPTH = 16;
`ifdef XXD_DELAY_LINE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [7:0] din_i;
    logic [4:0] delay_i;
    logic [7:0] dout_o;
    logic       dout_valid_o;
    logic [4:0] fill_o;
    logic       delay_err_o;

    xxd_delay_line #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .din_i        (din_i),
        .delay_i      (delay_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .fill_o       (fill_o),
        .delay_err_o  (delay_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: every accepted sample since reset, count since last flush, current D.
    logic [7:0] hist[$];
    int         cnt;
    int         dm;
    logic [7:0] m_dout;
    bit         m_known;
    bit         m_valid;
    bit         m_err;

    task automatic model_step(input bit r, input bit e, input logic [7:0] d, input logic [4:0] dl);
        int nd;
        int idx;
        if (r) begin
            hist.delete();
            cnt = 0; dm = 1; m_dout = 8'h00; m_known = 1'b1; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_err = (int'(dl) > DEPTH) || (dl == 5'd0 && !BYP);
            if (dl == 5'd0)          nd = BYP ? 0 : 1;
            else if (int'(dl) > DEPTH) nd = DEPTH;
            else                     nd = int'(dl);
            if (nd != dm) begin
                dm  = nd;
                cnt = 0;
            end
            m_valid = 1'b0;
            if (e) begin
                hist.push_back(d);
                if (dm == 0) begin
                    m_known = 1'b0;
                end else begin
                    idx     = hist.size() - dm;
                    m_valid = (cnt + 1 >= dm);
                    if (idx >= 0) begin
                        m_dout  = hist[idx];
                        m_known = 1'b1;
                    end else begin
                        m_known = 1'b0;
                    end
                end
                if (cnt < DEPTH) cnt++;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input logic [7:0] d, input logic [4:0] dl);
        rst_i = r; en_i = e; din_i = d; delay_i = dl;
        model_step(r, e, d, dl);
        @(posedge clk_i);
        #1;
        if (BYP && dl == 5'd0) begin
            check("bypass_dout", 32'(dout_o), 32'(d));
            check("bypass_valid", 32'(dout_valid_o), 32'(e));
        end else begin
            if (m_known) check("model_dout", 32'(dout_o), 32'(m_dout));
            check("model_valid", 32'(dout_valid_o), 32'(m_valid));
        end
        check("model_fill", 32'(fill_o), 32'(cnt));
        check("model_err", 32'(delay_err_o), 32'(m_err));
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] din;
        logic [4:0] dly;
        logic [7:0] dout;
        bit         valid;
        logic [4:0] fill;
        bit         err;
        bit         chk_dout;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] prev_din;
    logic [4:0] cur_dly;

    initial begin
        rst_i = 1'b1; en_i = 1'b0; din_i = 8'h00; delay_i = 5'd1;

        // delay=4, din=1..8, then delay=1 with gated en
        vecs.push_back('{1'b1, 1'b0, 8'h00, 5'd4, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back('{1'b0, 1'b1, 8'(k), 5'd4, 8'(k - 3), (k >= 4), 5'(k), 1'b0, (k >= 4)});
        end
        vecs.push_back('{1'b0, 1'b1, 8'hA5, 5'd1, 8'hA5, 1'b1, 5'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 5'd1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 8'h5A, 5'd1, 8'h5A, 1'b1, 5'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 5'd1, 8'h5A, 1'b0, 5'd2, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].dly);
            if (vecs[i].chk_dout) check($sformatf("tbl%0d_dout", i), 32'(dout_o), 32'(vecs[i].dout));
            check($sformatf("tbl%0d_valid", i), 32'(dout_valid_o), 32'(vecs[i].valid));
            check($sformatf("tbl%0d_fill", i), 32'(fill_o), 32'(vecs[i].fill));
            check($sformatf("tbl%0d_err", i), 32'(delay_err_o), 32'(vecs[i].err));
        end

        // delay=DEPTH across pointer wrap
        cyc(1'b1, 1'b0, 8'h00, 5'd16);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, 8'(i), 5'd16);
            check("wrap_valid", 32'(dout_valid_o), 32'(i >= 15));
        end
        check("wrap_dout", 32'(dout_o), 32'h18);

        // steady delay=4 at full fill, then switch to 2 coinciding with en
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i), 5'd4);
        check("steady_fill", 32'(fill_o), 32'd16);
        cyc(1'b0, 1'b1, 8'h70, 5'd2);
        check("switch_fill", 32'(fill_o), 32'd1);
        check("switch_valid", 32'(dout_valid_o), 32'd0);
        cyc(1'b0, 1'b1, 8'h71, 5'd2);
        check("resume_valid", 32'(dout_valid_o), 32'd1);
        check("resume_dout", 32'(dout_o), 32'h70);
        check("resume_fill", 32'(fill_o), 32'd2);

        // out-of-range delays
        cyc(1'b0, 1'b1, 8'h3C, 5'd0);
        check("zero_dout", 32'(dout_o), 32'h3C);
        check("zero_err", 32'(delay_err_o), BYP ? 32'd0 : 32'd1);
        cyc(1'b0, 1'b1, 8'h3D, 5'd20);
        check("high_err", 32'(delay_err_o), 32'd1);
        check("high_fill", 32'(fill_o), 32'd1);
        check("high_valid", 32'(dout_valid_o), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 5'd3);
        check("inrange_err", 32'(delay_err_o), 32'd0);

        // reset mid-stream with en high, then refill
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'h90 + i), 5'd4);
        cyc(1'b1, 1'b1, 8'hEE, 5'd4);
        check("rst_dout", 32'(dout_o), 32'd0);
        check("rst_valid", 32'(dout_valid_o), 32'd0);
        check("rst_fill", 32'(fill_o), 32'd0);
        check("rst_err", 32'(delay_err_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'(8'hB0 + i), 5'd4);
            check("refill_valid", 32'(dout_valid_o), 32'(i >= 3));
        end

        // randomized traffic against the model
        cur_dly  = 5'd5;
        prev_din = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) cur_dly = 5'($urandom_range(0, 20));
            prev_din = 8'($urandom);
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), prev_din, cur_dly);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
